// File: rtl/uc_coordena_entidades_param.sv
// rtl/uc_coordena_entidades_param.sv - game-tick coordination FSM walking enabled entity groups
module uc_coordena_entidades_param #(
    parameter int N_GRUPOS   = 2,
    parameter int LARG_GRUPO = 1,
    parameter int ITENS      = 16,
    parameter int LARG_IDX   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inicia,
    input  logic [N_GRUPOS-1:0]   habilita_grupo,
    input  logic [N_GRUPOS-1:0]   fim_compara,
    input  logic [N_GRUPOS-1:0]   fim_move,
    output logic [N_GRUPOS-1:0]   compara,
    output logic [N_GRUPOS-1:0]   movimenta,
    output logic [LARG_GRUPO-1:0] grupo_atual,
    output logic [LARG_IDX-1:0]   indice,
    output logic                  ocupado,
    output logic                  pronto,
    output logic                  erro_timeout,
    output logic [3:0]            db_estado
);

    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        PREPARA    = 4'd1,
        COMPARA    = 4'd2,
        ESPERA_C   = 4'd3,
        MOVE       = 4'd4,
        ESPERA_M   = 4'd5,
        PROX_ITEM  = 4'd6,
        PROX_GRUPO = 4'd7,
        FIM        = 4'd8,
        ERRO       = 4'd9
    } estado_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [LARG_IDX-1:0] ULTIMO = LARG_IDX'(ITENS - 1);
    localparam logic [CW-1:0]       LIMITE = CW'(TIMEOUT - 1);

    estado_t               estado, proximo;
    logic [N_GRUPOS-1:0]   mascara;
    logic [LARG_GRUPO-1:0] grupo;
    logic [LARG_IDX-1:0]   item;
    logic [CW-1:0]         espera;
    logic                  pendente;
    logic                  primeiro_ok, seguinte_ok, handshake, esgotado;
    logic [LARG_GRUPO-1:0] primeiro, seguinte;

    // Lowest enabled group for PREPARA (live mask) and next higher one for PROX_GRUPO (captured mask)
    always_comb begin
        primeiro_ok = 1'b0;
        primeiro    = '0;
        seguinte_ok = 1'b0;
        seguinte    = '0;
        for (int i = N_GRUPOS - 1; i >= 0; i--) begin
            if (habilita_grupo[i]) begin
                primeiro_ok = 1'b1;
                primeiro    = LARG_GRUPO'(i);
            end
            if (mascara[i] && (i > int'(grupo))) begin
                seguinte_ok = 1'b1;
                seguinte    = LARG_GRUPO'(i);
            end
        end
    end

    always_comb begin
        handshake = 1'b0;
        case (estado)
            ESPERA_C: handshake = fim_compara[grupo];
            ESPERA_M: handshake = fim_move[grupo];
            default:  handshake = 1'b0;
        endcase
    end

    assign esgotado = (espera == LIMITE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:     if (inicia || pendente) proximo = PREPARA;
            PREPARA:    proximo = primeiro_ok ? COMPARA : FIM;
            COMPARA:    proximo = ESPERA_C;
            ESPERA_C:   if (handshake) proximo = MOVE;
                        else if (esgotado) proximo = ERRO;
            MOVE:       proximo = ESPERA_M;
            ESPERA_M:   if (handshake) proximo = PROX_ITEM;
                        else if (esgotado) proximo = ERRO;
            PROX_ITEM:  proximo = (item == ULTIMO) ? PROX_GRUPO : COMPARA;
            PROX_GRUPO: proximo = seguinte_ok ? COMPARA : FIM;
            FIM:        proximo = OCIOSO;
            ERRO:       proximo = OCIOSO;
            default:    proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mascara      <= '0;
            grupo        <= '0;
            item         <= '0;
            espera       <= '0;
            pendente     <= 1'b0;
            erro_timeout <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: pendente <= 1'b0;
                PREPARA: begin
                    mascara      <= habilita_grupo;
                    item         <= '0;
                    erro_timeout <= 1'b0;
                    grupo        <= primeiro;
                end
                COMPARA, MOVE: espera <= '0;
                ESPERA_C, ESPERA_M: if (!handshake) espera <= espera + 1'b1;
                PROX_ITEM: if (item != ULTIMO) item <= item + 1'b1;
                PROX_GRUPO: begin
                    item <= '0;
                    if (seguinte_ok) grupo <= seguinte;
                end
                ERRO: erro_timeout <= 1'b1;
                default: ;
            endcase
            // Requests during a run collapse into one deferred restart
            if (estado != OCIOSO && inicia) pendente <= 1'b1;
        end
    end

    always_comb begin
        compara   = '0;
        movimenta = '0;
        if (estado == COMPARA) compara[grupo]   = 1'b1;
        if (estado == MOVE)    movimenta[grupo] = 1'b1;
        ocupado     = (estado != OCIOSO);
        pronto      = (estado == FIM);
        grupo_atual = grupo;
        indice      = item;
        db_estado   = estado;
    end

endmodule

// File: tb/tb_uc_coordena_entidades_param.sv
// tb/tb_uc_coordena_entidades_param.sv - directed self-checking bench for the coordination unit
module tb_uc_coordena_entidades_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       inicia;
    logic [1:0] habilita_grupo, fim_compara, fim_move;
    logic [1:0] compara, movimenta;
    logic [0:0] grupo_atual;
    logic [3:0] indice;
    logic       ocupado, pronto, erro_timeout;
    logic [3:0] db_estado;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    uc_coordena_entidades_param #(
        .N_GRUPOS(2), .LARG_GRUPO(1), .ITENS(4), .LARG_IDX(4), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset), .inicia(inicia),
        .habilita_grupo(habilita_grupo), .fim_compara(fim_compara), .fim_move(fim_move),
        .compara(compara), .movimenta(movimenta), .grupo_atual(grupo_atual),
        .indice(indice), .ocupado(ocupado), .pronto(pronto),
        .erro_timeout(erro_timeout), .db_estado(db_estado)
    );

    // Pulses inicia for one edge; returns at the negedge inside PREPARA (cycle 1)
    task automatic start_run();
        @(negedge clock) inicia = 1'b1;
        @(negedge clock) inicia = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; inicia = 1'b0;
        habilita_grupo = 2'b00; fim_compara = 2'b00; fim_move = 2'b00;
        #12;
        tests++;
        if ({compara, movimenta, grupo_atual, indice, ocupado, pronto, erro_timeout, db_estado} !== '0) begin
            failed++;
            $display("FAIL reset_outputs: got %h required 0",
                     {compara, movimenta, grupo_atual, indice, ocupado, pronto, erro_timeout, db_estado});
        end
        @(negedge clock) reset = 1'b1;
    endtask

    task automatic test_full_update();
        logic [1:0] cseq [8];
        logic [3:0] iseq [8];
        int ncmp = 0, npronto = 0, pronto_at = 0;
        habilita_grupo = 2'b11; fim_compara = 2'b11; fim_move = 2'b11;
        start_run();
        tests++;
        if (db_estado !== 4'd1) begin failed++; $display("FAIL full_prepara: got %0d required 1", db_estado); end
        for (int c = 1; c <= 50; c++) begin
            if (c > 1) @(negedge clock);
            if (compara != 2'b00) begin
                if (ncmp < 8) begin cseq[ncmp] = compara; iseq[ncmp] = indice; end
                ncmp++;
            end
            if (pronto) begin npronto++; pronto_at = c; end
        end
        tests++;
        if (ncmp !== 8) begin failed++; $display("FAIL full_strobe_count: got %0d required 8", ncmp); end
        for (int k = 0; k < 8 && k < ncmp; k++) begin
            tests++;
            if (cseq[k] !== ((k < 4) ? 2'b01 : 2'b10) || iseq[k] !== 4'(k % 4)) begin
                failed++;
                $display("FAIL full_seq_%0d: got compara=%b indice=%0d required compara=%b indice=%0d",
                         k, cseq[k], iseq[k], (k < 4) ? 2'b01 : 2'b10, k % 4);
            end
        end
        tests++;
        if (npronto !== 1 || pronto_at !== 44) begin
            failed++; $display("FAIL full_pronto: got count=%0d cycle=%0d required 1 at 44", npronto, pronto_at);
        end
        tests++;
        if (erro_timeout !== 1'b0 || ocupado !== 1'b0) begin
            failed++; $display("FAIL full_end_flags: got erro=%b ocupado=%b required 0 0", erro_timeout, ocupado);
        end
    endtask

    task automatic test_mask_upper();
        int nstrobe = 0, bad = 0, pronto_at = 0;
        habilita_grupo = 2'b10; fim_compara = 2'b11; fim_move = 2'b11;
        start_run();
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clock);
            if (compara[0] || movimenta[0]) bad++;
            if (db_estado >= 4'd2 && db_estado <= 4'd7 && grupo_atual !== 1'b1) bad++;
            if (compara != 2'b00) nstrobe++;
            if (pronto) pronto_at = c;
        end
        tests++;
        if (bad !== 0 || nstrobe !== 4) begin
            failed++; $display("FAIL mask10_group: got bad=%0d strobes=%0d required 0 4", bad, nstrobe);
        end
        tests++;
        if (pronto_at !== 23) begin failed++; $display("FAIL mask10_pronto: got %0d required 23", pronto_at); end
    endtask

    task automatic test_mask_empty();
        int nbusy = 0, nstrobe = 0, pronto_at = 0;
        habilita_grupo = 2'b00;
        start_run();
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clock);
            if (ocupado) nbusy++;
            if (compara != 2'b00 || movimenta != 2'b00) nstrobe++;
            if (pronto) pronto_at = c;
        end
        tests++;
        if (nbusy !== 2 || nstrobe !== 0 || pronto_at !== 2) begin
            failed++;
            $display("FAIL empty_mask: got busy=%0d strobes=%0d pronto=%0d required 2 0 2", nbusy, nstrobe, pronto_at);
        end
    endtask

    task automatic test_timeout();
        int npronto = 0;
        habilita_grupo = 2'b01; fim_compara = 2'b10; fim_move = 2'b11;
        start_run();
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) @(negedge clock);
            if (pronto) npronto++;
            if (c == 10) begin
                tests++;
                if (db_estado !== 4'd3) begin failed++; $display("FAIL to_wait8: got %0d required 3", db_estado); end
            end
            if (c == 11) begin
                tests++;
                if (db_estado !== 4'd9) begin failed++; $display("FAIL to_erro: got %0d required 9", db_estado); end
            end
        end
        tests++;
        if (erro_timeout !== 1'b1 || npronto !== 0 || ocupado !== 1'b0) begin
            failed++;
            $display("FAIL to_sticky: got erro=%b pronto=%0d ocupado=%b required 1 0 0", erro_timeout, npronto, ocupado);
        end
        fim_compara = 2'b11;
        start_run();
        @(negedge clock);
        tests++;
        if (erro_timeout !== 1'b0) begin failed++; $display("FAIL to_clear: got %b required 0", erro_timeout); end
        repeat (25) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int nprep = 0, npronto = 0, second = 0;
        habilita_grupo = 2'b11; fim_compara = 2'b11; fim_move = 2'b11;
        start_run();
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) @(negedge clock);
            if (db_estado == 4'd1) begin nprep++; if (c > 1) second = c; end
            if (pronto) npronto++;
            inicia = (c == 5 || c == 10) ? 1'b1 : 1'b0;
        end
        inicia = 1'b0;
        tests++;
        if (nprep !== 2 || second !== 46 || npronto !== 2) begin
            failed++;
            $display("FAIL pending: got prepara=%0d second=%0d pronto=%0d required 2 46 2", nprep, second, npronto);
        end
    endtask

    task automatic test_async_reset();
        int busy = 0;
        habilita_grupo = 2'b11; fim_compara = 2'b11; fim_move = 2'b11;
        start_run();
        @(negedge clock);
        @(negedge clock) inicia = 1'b1;
        @(negedge clock) inicia = 1'b0;
        tests++;
        if (movimenta !== 2'b01) begin failed++; $display("FAIL rst_in_move: got %b required 01", movimenta); end
        reset = 1'b0;
        #1;
        tests++;
        if (movimenta !== 2'b00 || ocupado !== 1'b0 || db_estado !== 4'd0) begin
            failed++;
            $display("FAIL rst_async: got mov=%b ocupado=%b estado=%0d required 00 0 0", movimenta, ocupado, db_estado);
        end
        #2 reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (ocupado || db_estado != 4'd0) busy++;
        end
        tests++;
        if (busy !== 0) begin failed++; $display("FAIL rst_idle: got %0d busy cycles required 0", busy); end
        start_run();
        tests++;
        if (db_estado !== 4'd1) begin failed++; $display("FAIL rst_restart: got %0d required 1", db_estado); end
        repeat (50) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_full_update();
        test_mask_upper();
        test_mask_empty();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uc_coordena_entidades_param.md
# uc_coordena_entidades_param

Parametrised coordination control unit for the game-tick update phase. On each request it walks every enabled entity group (shots, asteroids, ship, ...) in ascending group order. For each item of a group it issues a compare request and waits for its handshake, then issues a move request and waits again. Item indexing is internal. The block adds a per-group enable mask, a one-deep pending-request buffer and a handshake watchdog.

## Interface
Parameters:
- N_GRUPOS, 2, number of entity groups (channels), 1..8
- LARG_GRUPO, 1, width of group index, ≥ clog2(N_GRUPOS), min 1
- ITENS, 16, items per group, 1..2^LARG_IDX
- LARG_IDX, 4, width of item index
- TIMEOUT, 255, max cycles waited on any handshake, ≥ 2

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- inicia  in  1  update request, sampled every edge
- habilita_grupo  in  N_GRUPOS  group enable mask, captured in PREPARA
- fim_compara  in  N_GRUPOS  per-group compare-done handshake (level)
- fim_move  in  N_GRUPOS  per-group move-done handshake (level)
- compara  out  N_GRUPOS  one-hot compare strobe
- movimenta  out  N_GRUPOS  one-hot move strobe
- grupo_atual  out  LARG_GRUPO  group being served
- indice  out  LARG_IDX  item being served
- ocupado  out  1  high in every state except OCIOSO
- pronto  out  1  one-cycle end-of-update pulse
- erro_timeout  out  1  sticky watchdog flag
- db_estado  out  4  state code for debug display

## Operation
- All outputs are Moore outputs decoded from registered state. Reset values: every output 0, db_estado=0, internal pendente=0, mask register=0.
- States and db_estado codes:
  - OCIOSO(0): idle; goes to PREPARA if inicia or pendente; clears pendente.
  - PREPARA(1): captures mask, indice=0, erro_timeout←0. Selects lowest enabled group. If none is enabled, goes to FIM.
  - COMPARA(2): compara[g]=1 for exactly this cycle; goes to ESPERA_C.
  - ESPERA_C(3): waits for fim_compara[g]; then goes to MOVE.
  - MOVE(4): movimenta[g]=1 for exactly this cycle; goes to ESPERA_M.
  - ESPERA_M(5): waits for fim_move[g]; then goes to PROX_ITEM.
  - PROX_ITEM(6): if indice==ITENS-1, goes to PROX_GRUPO; otherwise indice+1 and goes to COMPARA.
  - PROX_GRUPO(7): indice=0. Selects the next higher enabled group and goes to COMPARA. If none remains, goes to FIM.
  - FIM(8): pronto=1; goes to OCIOSO.
  - ERRO(9): erro_timeout←1; goes to OCIOSO. pronto is not asserted.
- Handshakes:
  - fim_* is evaluated only in the matching ESPERA state, and only the bit of the current group.
  - A level already high on entry is accepted on the first ESPERA cycle.
  - Bits of other groups are ignored.
- Watchdog:
  - The counter clears on entering each ESPERA state and increments each ESPERA cycle while the handshake is low.
  - When the TIMEOUT-th waiting cycle ends with the handshake still low, the next state is ERRO.
  - A handshake arriving on that same cycle wins; no error is raised.
- erro_timeout stays high until the next PREPARA.
- Pending request: inicia=1 in any state other than OCIOSO sets pendente. After FIM or ERRO the block returns to OCIOSO and starts again the next cycle. Extra requests beyond one are merged.
- Changing habilita_grupo mid-update has no effect until the next PREPARA.
- grupo_atual and indice stay stable from COMPARA through PROX_ITEM of an item.
- Mid-operation reset: outputs drop to 0 asynchronously, pendente is cleared, and the block resumes in OCIOSO on the first edge after release.

## Timing
- inicia sampled high in OCIOSO → PREPARA on the next cycle → first COMPARA one cycle later.
- Per item with immediate handshakes: 5 cycles (COMPARA, ESPERA_C, MOVE, ESPERA_M, PROX_ITEM). Each handshake delay of k cycles adds k.
- Full update with immediate handshakes: 1 (PREPARA) + E·(5·ITENS+1) + 1 (FIM), where E = number of enabled groups. pronto is high in the last of those cycles.
- Empty mask: pronto is high 2 cycles after PREPARA entry (PREPARA, FIM).
- ocupado rises in the cycle after inicia is sampled and falls in the cycle after FIM or ERRO.

## Test plan
1. N_GRUPOS=2, ITENS=4, mask=2'b11, fim_* tied high, inicia pulsed 1 cycle. Required: compara sequence 01,01,01,01,10,10,10,10 with indice 0..3 per group; pronto in cycle 44 after PREPARA entry; erro_timeout=0.
2. mask=2'b10, handshakes high. Required: group 0 is never strobed, grupo_atual=1 throughout, pronto in cycle 23.
3. mask=0. Required: no strobes, pronto in cycle 2, ocupado high for exactly 2 cycles.
4. TIMEOUT=8, fim_compara held low. Required: ERRO after 8 ESPERA_C cycles, erro_timeout=1 sticky, pronto never pulses; a following inicia clears erro_timeout in PREPARA.
5. inicia pulsed again while in ESPERA_M. Required: after FIM, exactly one extra PREPARA follows immediately; a third pulse in the same window produces no additional run.
6. reset driven to 0 for half a cycle while in MOVE. Required: movimenta, ocupado and db_estado read 0 before the next edge; the block idles until a new inicia.
